dag_path_counter: RTL and testbench
===================================

# dag_path_counter

Initiator side of the adjacency query/reply protocol. After input decoding completes, it walks the DAG from `start_node` with an iterative depth-first search on an explicit LIFO stack. For each non-terminal node it issues one query to the adjacency map and pushes every returned child onto the stack. It counts how many times `end_node` is popped, which is the number of distinct start→end paths, and reports the total once the stack drains.

## Interface
- `NODE_WIDTH`, 10: node index width; must match the adjacency map.
- `STACK_DEPTH`, 256: LIFO entries; power of two.
- `COUNT_WIDTH`, 48: path counter width.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `decoding_done` in 1: level; graph fully loaded into the adjacency map.
- `start_node` in NODE_WIDTH: source node; sampled in IDLE.
- `end_node` in NODE_WIDTH: target node; must stay stable until `done`.
- `query_ready` in 1: responder accepts a query.
- `query_valid` out 1: query pending.
- `query_data` out NODE_WIDTH: node being expanded.
- `reply_ready` out 1: block accepts a reply beat.
- `reply_valid` in 1: reply beat present.
- `reply_last` in 1: final child of the current reply.
- `reply_data` in NODE_WIDTH: child node.
- `path_count` out COUNT_WIDTH: running or final path total.
- `done` out 1: search complete; sticky until `rst`.
- `overflow` out 1: a push was dropped on a full stack; sticky until `rst`. When set, `path_count` is invalid.

## Operation
- States:
  - IDLE → PUSH_START when `decoding_done`=1.
  - PUSH_START: push `start_node`, → POP.
  - POP:
    - Stack empty → DONE.
    - Else pop the top. Top == `end_node`: increment the count, stay in POP.
    - Otherwise latch the top into `query_data`, → QUERY.
  - QUERY: `query_valid`=1 until `query_ready`. On handshake → COLLECT.
  - COLLECT: `reply_ready`=1. Every beat with `reply_valid`&&`reply_ready` pushes `reply_data`. A beat that also has `reply_last` → POP.
  - DONE: `done`=1, terminal.
- Preconditions:
  - The graph is acyclic.
  - Every queried node has at least one outgoing edge. `end_node` is the only sink and is never queried.
  - The responder never returns zero beats.
- Push on a full stack: the entry is dropped, `overflow` is set, and the search continues until the stack empties, so the protocol stays in sync.
- The stack pointer never wraps. A pop on an empty stack is impossible by construction.
- `start_node` == `end_node`: count=1, no query issued, `done` after the first POP.
- Counter wraps modulo 2^COUNT_WIDTH unless saturation is compiled in (see Configuration).
- `decoding_done` deasserting after leaving IDLE is ignored. One search per reset.

## Timing
- Reset values: `query_valid`=0, `reply_ready`=0, `path_count`=0, `done`=0, `overflow`=0, `query_data`=0, stack empty, state IDLE.
- `rst` is honoured in any state. All outputs return to their reset values the next cycle. Outstanding reply beats are not drained, so the adjacency map must be reset together with this block.
- IDLE→PUSH_START→POP: 2 cycles after `decoding_done` is sampled high.
- POP takes one cycle per entry; an `end_node` hit increments `path_count` on that edge.
- `query_valid` rises the cycle after POP. `query_data` stays stable while `query_valid`=1 and `query_ready`=0.
- `reply_ready` is high every COLLECT cycle, allowing one push per cycle with no bubbles.
- After the `reply_last` beat there is one cycle to POP.
- `done` rises the cycle after POP sees an empty stack. `path_count` is final from that cycle onward.
- `query_valid` and `reply_ready` are never high together.

## Configuration
- `DAG_PATH_COUNTER_SATURATE_EN`:
  - Defined: `path_count` holds at all-ones once reached; further hits are ignored.
  - Undefined: `path_count` wraps to 0 after all-ones.
  - `overflow` is unaffected either way.

## Test plan
- Chain 0→1→2, start=0, end=2, responder always ready → `path_count`=1, `done`=1, exactly 2 queries (nodes 0, 1).
- Diamond 0→{1,2}, 1→3, 2→3, start=0, end=3 → `path_count`=2, 3 queries, `overflow`=0.
- Diamond as above; `query_ready` delayed 5 cycles, `reply_valid` gapped every other cycle → `path_count`=2; `query_data` stable during each stall.
- STACK_DEPTH=4, node 0 with 6 children all equal to end=7 → `overflow`=1, `done`=1, `path_count`=4.
- start=end=5 → `path_count`=1, `query_valid` never asserted, `done` 3 cycles after `decoding_done`.
- COUNT_WIDTH=2, 5 parallel paths 0→{1..5}→9 → `path_count`=3 with the macro defined, 1 without. `rst` pulsed mid-COLLECT → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/dag_path_counter.sv
// Counts start->end paths through a DAG via iterative DFS on a LIFO stack, querying the adjacency map per expanded node.
// One pop per cycle, stalls on query_ready / reply_valid; DAG_PATH_COUNTER_SATURATE_EN makes path_count saturate instead of wrap.
module dag_path_counter #(
  parameter int NODE_WIDTH  = 10,
  parameter int STACK_DEPTH = 256,
  parameter int COUNT_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   decoding_done,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  end_node,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  output logic                   reply_ready,
  input  logic                   reply_valid,
  input  logic                   reply_last,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  output logic [COUNT_WIDTH-1:0] path_count,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [AW:0] SP_FULL = (AW+1)'(STACK_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PUSH_START = 3'd1;
  localparam logic [2:0] S_POP        = 3'd2;
  localparam logic [2:0] S_QUERY      = 3'd3;
  localparam logic [2:0] S_COLLECT    = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [AW:0]            sp_q, sp_d;
  logic [NODE_WIDTH-1:0]  qdata_q, qdata_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [NODE_WIDTH-1:0]  stack_q [STACK_DEPTH];

  logic                   push_en;
  logic [NODE_WIDTH-1:0]  push_data;
  logic                   full;
  logic [AW:0]            sp_dec;
  logic [NODE_WIDTH-1:0]  top;
  logic [COUNT_WIDTH-1:0] count_inc;

  assign full   = (sp_q == SP_FULL);
  assign sp_dec = sp_q - 1'b1;
  assign top    = stack_q[sp_dec[AW-1:0]];

`ifdef DAG_PATH_COUNTER_SATURATE_EN
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
`else
  assign count_inc = count_q + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    qdata_d   = qdata_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    push_en   = 1'b0;
    push_data = '0;
    case (state_q)
      S_IDLE: begin
        if (decoding_done) state_d = S_PUSH_START;
      end
      S_PUSH_START: begin
        push_en   = 1'b1;
        push_data = start_node;
        state_d   = S_POP;
      end
      S_POP: begin
        if (sp_q == '0) begin
          state_d = S_DONE;
        end else begin
          sp_d = sp_dec;
          if (top == end_node) begin
            count_d = count_inc;
          end else begin
            qdata_d = top;
            state_d = S_QUERY;
          end
        end
      end
      S_QUERY: begin
        if (query_ready) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (reply_valid) begin
          push_en   = 1'b1;
          push_data = reply_data;
          if (reply_last) state_d = S_POP;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // A push into a full stack is dropped but the walk keeps going so the reply stream stays aligned.
    if (push_en) begin
      if (full) ovf_d = 1'b1;
      else      sp_d  = sp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      qdata_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      qdata_q <= qdata_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !full) stack_q[sp_q[AW-1:0]] <= push_data;
  end

  assign query_valid = (state_q == S_QUERY);
  assign reply_ready = (state_q == S_COLLECT);
  assign query_data  = qdata_q;
  assign path_count  = count_q;
  assign done        = (state_q == S_DONE);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_dag_path_counter.sv
// Directed bench for dag_path_counter: a behavioural adjacency responder serves two instances (shallow stack / narrow counter).
module tb_dag_path_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic       rst [2];
  logic       dd  [2];
  logic       qr  [2];
  logic       rv  [2];
  logic       rl  [2];
  logic [9:0] sn  [2];
  logic [9:0] en  [2];
  logic [9:0] rd  [2];
  logic       qv  [2];
  logic       rr  [2];
  logic       dn  [2];
  logic       ov  [2];
  logic [9:0] qd  [2];
  logic [47:0] pc0;
  logic [1:0]  pc1;

  dag_path_counter #(.NODE_WIDTH(10), .STACK_DEPTH(4), .COUNT_WIDTH(48)) u0 (
    .clk(clk), .rst(rst[0]), .decoding_done(dd[0]), .start_node(sn[0]), .end_node(en[0]),
    .query_ready(qr[0]), .query_valid(qv[0]), .query_data(qd[0]), .reply_ready(rr[0]),
    .reply_valid(rv[0]), .reply_last(rl[0]), .reply_data(rd[0]), .path_count(pc0),
    .done(dn[0]), .overflow(ov[0]));

  dag_path_counter #(.NODE_WIDTH(10), .STACK_DEPTH(8), .COUNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst[1]), .decoding_done(dd[1]), .start_node(sn[1]), .end_node(en[1]),
    .query_ready(qr[1]), .query_valid(qv[1]), .query_data(qd[1]), .reply_ready(rr[1]),
    .reply_valid(rv[1]), .reply_last(rl[1]), .reply_data(rd[1]), .path_count(pc1),
    .done(dn[1]), .overflow(ov[1]));

  int adj_n [16];
  int adj_c [16][8];

  int qlog [32];
  int nq;
  bit stall_bad, both_bad, qv_seen, timed_out;
  int done_at;

  task automatic clear_adj();
    for (int i = 0; i < 16; i++) adj_n[i] = 0;
  endtask

  task automatic add_edge(input int a, input int b);
    adj_c[a][adj_n[a]] = b;
    adj_n[a]++;
  endtask

  task automatic start_search(input int inst, input int s, input int e);
    @(negedge clk);
    rst[inst] = 1'b1; dd[inst] = 1'b0;
    qr[inst] = 1'b0; rv[inst] = 1'b0; rl[inst] = 1'b0;
    sn[inst] = 10'(s); en[inst] = 10'(e);
    repeat (2) @(negedge clk);
    rst[inst] = 1'b0;
    @(negedge clk);
    dd[inst] = 1'b1;
  endtask

  // Acts as the adjacency map: answers queries from adj tables, optionally stalling.
  task automatic service(input int inst, input int qdelay, input bit gap,
                         input int max_cyc, input int stop_at_collect);
    int wait_cnt, cur, beat, collects;
    bit tog, prev_stall, prev_rr;
    logic [9:0] prev_qd;
    wait_cnt = 0; cur = 0; beat = 0; collects = 0;
    tog = 1'b0; prev_stall = 1'b0; prev_rr = 1'b0; prev_qd = '0;
    nq = 0; stall_bad = 0; both_bad = 0; qv_seen = 0; done_at = -1; timed_out = 1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (qv[inst] && rr[inst]) both_bad = 1;
      if (qv[inst]) qv_seen = 1;
      if (prev_stall && qv[inst] && qd[inst] !== prev_qd) stall_bad = 1;
      if (dn[inst]) begin
        done_at = c - 1; timed_out = 0;
        break;
      end
      if (rr[inst] && !prev_rr) begin
        collects++;
        if (stop_at_collect > 0 && collects == stop_at_collect) begin
          timed_out = 0;
          break;
        end
      end
      prev_rr = rr[inst];
      qr[inst] = 1'b0; rv[inst] = 1'b0; rl[inst] = 1'b0; prev_stall = 1'b0;
      if (qv[inst]) begin
        if (wait_cnt < qdelay) begin
          wait_cnt++; prev_stall = 1'b1; prev_qd = qd[inst];
        end else begin
          qr[inst] = 1'b1; wait_cnt = 0;
          cur = int'(qd[inst]) % 16; beat = 0; tog = 1'b0;
          if (nq < 32) qlog[nq] = int'(qd[inst]);
          nq++;
        end
      end
      if (rr[inst]) begin
        if ((!gap || tog) && beat < 8) begin
          rv[inst] = 1'b1;
          rd[inst] = 10'(adj_c[cur][beat]);
          rl[inst] = (beat == adj_n[cur] - 1);
          beat++;
        end
        tog = ~tog;
      end
    end
    qr[inst] = 1'b0; rv[inst] = 1'b0; rl[inst] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst[0] = 1'b1; dd[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    vectors++; if (qv[0] !== 1'b0) begin miscompares++; $display("FAIL reset_query_valid: got %b expected 0", qv[0]); end
    vectors++; if (rr[0] !== 1'b0) begin miscompares++; $display("FAIL reset_reply_ready: got %b expected 0", rr[0]); end
    vectors++; if (pc0 !== 48'd0) begin miscompares++; $display("FAIL reset_path_count: got %0d expected 0", pc0); end
    vectors++; if (dn[0] !== 1'b0 || ov[0] !== 1'b0) begin miscompares++; $display("FAIL reset_done_ovf: got %b%b expected 00", dn[0], ov[0]); end
    vectors++; if (qd[0] !== 10'd0) begin miscompares++; $display("FAIL reset_query_data: got %0d expected 0", qd[0]); end
  endtask

  task automatic test_chain();
    clear_adj(); add_edge(0, 1); add_edge(1, 2);
    start_search(0, 0, 2);
    service(0, 0, 1'b0, 500, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL chain_timeout: done not seen within budget"); end
    vectors++; if (pc0 !== 48'd1) begin miscompares++; $display("FAIL chain_count: got %0d expected 1", pc0); end
    vectors++; if (nq !== 2) begin miscompares++; $display("FAIL chain_queries: got %0d expected 2", nq); end
    vectors++; if (qlog[0] !== 0 || qlog[1] !== 1) begin miscompares++; $display("FAIL chain_query_nodes: got %0d,%0d expected 0,1", qlog[0], qlog[1]); end
    vectors++; if (both_bad !== 1'b0) begin miscompares++; $display("FAIL chain_qv_rr_overlap: got %b expected 0", both_bad); end
  endtask

  task automatic test_diamond(input int qdelay, input bit gap);
    clear_adj(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    start_search(0, 0, 3);
    service(0, qdelay, gap, 1000, 0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL diamond_timeout: delay %0d not done within budget", qdelay); end
    vectors++; if (pc0 !== 48'd2) begin miscompares++; $display("FAIL diamond_count: delay %0d got %0d expected 2", qdelay, pc0); end
    vectors++; if (nq !== 3) begin miscompares++; $display("FAIL diamond_queries: got %0d expected 3", nq); end
    vectors++; if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL diamond_overflow: got %b expected 0", ov[0]); end
    vectors++; if (stall_bad !== 1'b0 || both_bad !== 1'b0) begin miscompares++; $display("FAIL diamond_stall_stable: got stall_bad=%b overlap=%b expected 0,0", stall_bad, both_bad); end
  endtask

  task automatic test_overflow();
    clear_adj();
    for (int i = 0; i < 6; i++) add_edge(0, 7);
    start_search(0, 0, 7);
    service(0, 0, 1'b0, 500, 0);
    vectors++; if (dn[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_done: got %b expected 1", dn[0]); end
    vectors++; if (ov[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", ov[0]); end
    vectors++; if (pc0 !== 48'd4) begin miscompares++; $display("FAIL ovf_count: got %0d expected 4", pc0); end
  endtask

  task automatic test_start_is_end();
    clear_adj();
    start_search(0, 5, 5);
    service(0, 0, 1'b0, 100, 0);
    vectors++; if (pc0 !== 48'd1) begin miscompares++; $display("FAIL same_count: got %0d expected 1", pc0); end
    vectors++; if (qv_seen !== 1'b0) begin miscompares++; $display("FAIL same_no_query: got %b expected 0", qv_seen); end
    vectors++; if (done_at !== 3) begin miscompares++; $display("FAIL same_done_latency: got %0d expected 3", done_at); end
  endtask

  task automatic test_mid_reset();
    clear_adj();
    for (int k = 1; k <= 5; k++) begin add_edge(0, k); add_edge(k, 9); end
    start_search(1, 0, 9);
    service(1, 0, 1'b0, 500, 3);
    vectors++; if (rr[1] !== 1'b1 || qd[1] !== 10'd4 || pc1 !== 2'd1) begin miscompares++; $display("FAIL midrst_pre: got rr=%b qd=%0d pc=%0d expected 1,4,1", rr[1], qd[1], pc1); end
    rst[1] = 1'b1; dd[1] = 1'b0;
    @(negedge clk);
    vectors++; if (qv[1] !== 1'b0 || rr[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_handshake: got qv=%b rr=%b expected 0,0", qv[1], rr[1]); end
    vectors++; if (pc1 !== 2'd0 || qd[1] !== 10'd0) begin miscompares++; $display("FAIL midrst_data: got pc=%0d qd=%0d expected 0,0", pc1, qd[1]); end
    vectors++; if (dn[1] !== 1'b0 || ov[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_flags: got done=%b ovf=%b expected 0,0", dn[1], ov[1]); end
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (qv[1] !== 1'b0 || dn[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got qv=%b done=%b expected 0,0", qv[1], dn[1]); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_pc;
`ifdef DAG_PATH_COUNTER_SATURATE_EN
    exp_pc = 2'd3;
`else
    exp_pc = 2'd1;
`endif
    clear_adj();
    for (int k = 1; k <= 5; k++) begin add_edge(0, k); add_edge(k, 9); end
    start_search(1, 0, 9);
    service(1, 0, 1'b0, 500, 0);
    vectors++; if (dn[1] !== 1'b1) begin miscompares++; $display("FAIL wrap_done: got %b expected 1", dn[1]); end
    vectors++; if (pc1 !== exp_pc) begin miscompares++; $display("FAIL wrap_count: got %0d expected %0d", pc1, exp_pc); end
    vectors++; if (nq !== 6 || ov[1] !== 1'b0) begin miscompares++; $display("FAIL wrap_queries: got nq=%0d ovf=%b expected 6,0", nq, ov[1]); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; dd[i] = 1'b0; qr[i] = 1'b0; rv[i] = 1'b0; rl[i] = 1'b0;
      sn[i] = '0; en[i] = '0; rd[i] = '0;
    end
    test_reset();
    test_chain();
    test_diamond(0, 1'b0);
    test_diamond(5, 1'b1);
    test_overflow();
    test_start_is_end();
    test_mid_reset();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
